// File: rtl/rst_seq_pkg.sv
// Shared types and default parameters for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } rst_seq_state_t;

  localparam int RST_SEQ_SYNC_STAGES = 2;
  localparam int RST_SEQ_NUM_OUT     = 3;
  localparam int RST_SEQ_HOLD_CYCLES = 8;

  // Index register width; a single domain still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Reset-deassertion synchronizer: cleared asynchronously, shifts in ones on clk.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rel
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign rel = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: synchronizes board reset release, then releases NUM_OUT
// domains one at a time with a fixed gap; a soft request replays the sequence.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = RST_SEQ_SYNC_STAGES,
  parameter int NUM_OUT     = RST_SEQ_NUM_OUT,
  parameter int HOLD_CYCLES = RST_SEQ_HOLD_CYCLES,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               soft_req,
  output logic               soft_ack,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               done
);

  localparam int IDX_W = idx_width(NUM_OUT);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("rst_seq: SYNC_STAGES must be >= 2");
    end
    if (NUM_OUT < 1) begin : g_bad_num
      $error("rst_seq: NUM_OUT must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("rst_seq: HOLD_CYCLES must be >= 1");
    end
  endgenerate

  logic sync_rel;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .rel  (sync_rel)
  );

  rst_seq_state_t     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_out_n_q, rst_out_n_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
  logic               done_q, done_d;
  logic               soft_ack_q, soft_ack_d;
  logic               soft_flag_q, soft_flag_d;
  logic               req_prev_q, req_prev_d;
  logic               soft_rise;
  logic               advance;

  assign soft_rise  = soft_req & ~req_prev_q;
  assign req_prev_d = soft_req;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rst_out_n_d = rst_out_n_q;
    done_d      = done_q;
    soft_ack_d  = 1'b0;
    soft_flag_d = soft_flag_q;
    advance     = 1'b0;
    cnt_inc     = cnt_q + 1'b1;

    case (state_q)
      SYNC: advance = sync_rel;
      HOLD: advance = 1'b1;
      RUN: begin
        if (soft_rise) begin
          rst_out_n_d = '0;
          done_d      = 1'b0;
          idx_d       = '0;
          cnt_d       = '0;
          soft_flag_d = 1'b1;
          state_d     = HOLD;
        end
      end
      default: state_d = SYNC;
    endcase

    // The edge that leaves SYNC already counts as the first hold cycle.
    if (advance) begin
      state_d = HOLD;
      if (cnt_inc == CNT_W'(HOLD_CYCLES)) begin
        cnt_d = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
          if (idx_q == IDX_W'(i)) begin
            rst_out_n_d[i] = 1'b1;
          end
        end
        if (idx_q == IDX_W'(NUM_OUT - 1)) begin
          state_d     = RUN;
          done_d      = 1'b1;
          soft_ack_d  = soft_flag_q;
          soft_flag_d = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_inc;
      end
    end

    rst_out_d = ~rst_out_n_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SYNC;
      cnt_q       <= '0;
      idx_q       <= '0;
      rst_out_n_q <= '0;
      rst_out_q   <= '1;
      done_q      <= 1'b0;
      soft_ack_q  <= 1'b0;
      soft_flag_q <= 1'b0;
      req_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rst_out_n_q <= rst_out_n_d;
      rst_out_q   <= rst_out_d;
      done_q      <= done_d;
      soft_ack_q  <= soft_ack_d;
      soft_flag_q <= soft_flag_d;
      req_prev_q  <= req_prev_d;
    end
  end

  assign rst_out_n = rst_out_n_q;
  assign rst_out   = rst_out_q;
  assign done      = done_q;
  assign soft_ack  = soft_ack_q;

endmodule

// File: doc/rst_seq.md
# rst_seq

Reset sequencer that produces the resets consumed by the lab's asynchronous-reset registers. It takes the board-level asynchronous active-low reset and synchronizes its deassertion to `clk`. It then releases `NUM_OUT` downstream reset domains one at a time, with a fixed hold gap between releases. A software-triggered reset request and acknowledge handshake re-runs the same sequence without a board reset.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the reset-deassertion synchronizer; must be ≥2.
- `NUM_OUT`, 3: number of sequenced reset domains; must be ≥1.
- `HOLD_CYCLES`, 8: `clk` cycles between consecutive releases; must be ≥1.
- `CNT_W`, `$clog2(HOLD_CYCLES+1)`: hold-counter width (derived).

Ports:
- `clk`  in  1  single clock for the block.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `soft_req`  in  1  soft-reset request; its rising edge is sampled only in RUN.
- `soft_ack`  out  1  one-cycle pulse when a soft-triggered sequence completes.
- `rst_out_n`  out  NUM_OUT  per-domain reset, active-low; bit 0 is released first.
- `rst_out`  out  NUM_OUT  per-domain reset, active-high; always `~rst_out_n`, for active-high consumers.
- `done`  out  1  high only when every domain is released (RUN).

## Operation
Reset values (forced immediately while `rst_n`=0):
- `rst_out_n`=0, `rst_out`=all 1s, `done`=0, `soft_ack`=0.
- FSM=SYNC, synchronizer chain=0, hold counter=0, index=0.

FSM states:
- SYNC: wait for the synchronizer output to go high, then go to HOLD.
- HOLD: count `HOLD_CYCLES` cycles, then release `rst_out_n[idx]`.
  - If `idx`=`NUM_OUT-1`, go to RUN.
  - Otherwise increment `idx`, clear the counter and stay in HOLD.
- RUN: `done`=1.
  - A rising edge of `soft_req` (0 on the previous cycle, 1 now) asserts all `rst_out_n` to 0, clears `done`, `idx` and the counter, sets the soft flag and goes to HOLD.
- On entering RUN with the soft flag set: pulse `soft_ack` for one cycle and clear the flag.

Boundary conditions:
- `soft_req` is ignored outside RUN; a request made during a sequence is dropped, not queued.
- `soft_req` held high across RUN entry does not retrigger; it must drop low first.
- `rst_n` asserted mid-sequence or mid-soft-sequence: all outputs reassert asynchronously, the soft flag clears, no `soft_ack` is issued, and the FSM restarts in SYNC.
- A `rst_n` glitch shorter than one cycle still fully restarts the sequence.
- Released bits never reassert except by `rst_n` or a soft request.

## Timing
- All outputs are registered; assertion through `rst_n` is asynchronous and deassertion is synchronous to `clk`.
- Let edge 1 be the first `clk` rising edge sampling `rst_n`=1.
  - `rst_out_n[0]` rises at edge `SYNC_STAGES+HOLD_CYCLES`.
  - `rst_out_n[i]` rises `HOLD_CYCLES` edges after `rst_out_n[i-1]`.
  - `done` rises on the same edge as `rst_out_n[NUM_OUT-1]`.
- With defaults: releases at edges 10, 18 and 26; `done` at edge 26.
- Soft sequence, with the rising edge of `soft_req` sampled at edge e:
  - All outputs assert after edge e.
  - `rst_out_n[i]` rises at edge e+(i+1)·`HOLD_CYCLES`.
  - `done` and `soft_ack` rise at edge e+`NUM_OUT`·`HOLD_CYCLES`.
  - `soft_ack` lasts exactly one cycle.

## Structure
- Package `rst_seq_pkg`:
  - State typedef `rst_seq_state_t` {SYNC, HOLD, RUN}.
  - Default constants `RST_SEQ_SYNC_STAGES`, `RST_SEQ_NUM_OUT`, `RST_SEQ_HOLD_CYCLES`.
- Sub-module `rst_sync`: parameterized `SYNC_STAGES` flop chain.
  - Asynchronously cleared by `rst_n`; shifts in 1 each clock.
  - Output is the synchronized reset release.
- Top level holds the FSM, hold counter, index register, soft-request edge detector and output registers.

## Test plan
- Power-on, defaults: `rst_n` low for 3 cycles then high. `rst_out_n` goes 000→001 at edge 10, 011 at edge 18, 111 at edge 26. `done`=1 at edge 26. `rst_out`=`~rst_out_n` throughout.
- Soft reset: in RUN, `soft_req` 0→1 at edge e. `rst_out_n`=000 after e, then 001/011/111 at e+8, e+16, e+24. `soft_ack` high only on the cycle after edge e+24.
- Held request: keep `soft_req`=1 through the whole soft sequence. Exactly one sequence and one `soft_ack`. Dropping low then high starts a second sequence.
- Request mid-sequence: pulse `soft_req` at edge 14 after power-on. Releases still occur at 10, 18 and 26; no `soft_ack`.
- Mid-operation reset: drive `rst_n` low for a sub-cycle glitch between edges 18 and 26. Outputs go to 000 immediately. The release sequence restarts from the first post-glitch sampled-high edge; no `soft_ack`.
- Parameter sweep `NUM_OUT`=1, `HOLD_CYCLES`=1, `SYNC_STAGES`=3: `rst_out_n[0]` and `done` rise at edge 4.
